// File: rtl/input_event_pkg.sv
// ============================================================================
// Module      : input_event_pkg
// Description : Shared types and helpers for the input event arbiter:
//               arbiter state encoding, event-channel index width and the
//               round-robin selection function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package input_event_pkg;

    // Largest supported channel count; the round-robin helper works on a
    // request vector padded to this width.
    localparam int c_MAX_CH = 16;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } arb_state_t;

    // Channel index width, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // First set request strictly after ptr, wrapping over n entries.
    // Returns 0 when nothing is requested; callers qualify with |req.
    function automatic logic [3:0] rr_next(
        input logic [c_MAX_CH-1:0] req,
        input logic [3:0]          ptr,
        input int                  n
    );
        logic [3:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= c_MAX_CH; k++) begin
            idx = (int'(ptr) + k) % n;
            if (!found && (k <= n) && req[4'(idx)]) begin
                pick  = 4'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/input_conditioner.sv
// ============================================================================
// Module      : input_conditioner
// Description : One input channel: synchroniser chain, debounce counter and
//               edge pulses on the debounced level.
// Ports       : clk, rst_n      - clock, async active-low reset
//               raw             - asynchronous raw input
//               level           - debounced level
//               pos / neg       - one-cycle pulse (combinational) asserted
//                                 on the edge where level rises / falls
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_conditioner #(
    parameter int   SYNC_STAGES = 2,
    parameter int   DEB_LEN     = 5,
    parameter logic INIT_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic pos,
    output logic neg
);

    localparam int                 c_CNT_W    = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_level;
    logic                   w_sync_out;
    logic                   w_differ;
    logic                   w_flip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{INIT_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_differ   = (w_sync_out != r_level);
    // The count holds DEB_LEN-1 differing samples already; this one completes
    // the run, so the level flips now instead of the count reaching DEB_LEN.
    assign w_flip     = w_differ && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= INIT_VAL;
        end else if (w_flip) begin
            r_cnt   <= '0;
            r_level <= w_sync_out;
        end else if (w_differ) begin
            r_cnt   <= r_cnt + 1'b1;
        end else begin
            r_cnt   <= '0;
        end
    end

    assign level = r_level;
    assign pos   = w_flip &&  w_sync_out;
    assign neg   = w_flip && !w_sync_out;

endmodule

`default_nettype wire

// File: rtl/input_event_arbiter.sv
// ============================================================================
// Module      : input_event_arbiter
// Description : Conditions CH_NUM asynchronous inputs and merges their
//               debounced edges into one valid/ready event stream with a
//               single pending slot per channel and round-robin arbitration.
// Ports       : clk, rst_n      - clock, async active-low reset
//               input_signal    - raw asynchronous inputs
//               level_out       - debounced levels
//               evt_valid/ready - event handshake
//               evt_ch/evt_pol  - channel index / 1 = rising edge
//               overflow        - sticky per-channel lost-event flags
//               ovf_clr         - clears overflow (a same-cycle set wins)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_event_arbiter
    import input_event_pkg::*;
#(
    parameter int   CH_NUM      = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   DEB_LEN     = 5,
    parameter logic INIT_VAL    = 1'b0,
    parameter bit   POS_ENABLE  = 1'b1,
    parameter bit   NEG_ENABLE  = 1'b1,
    localparam int  CH_W        = ch_width(CH_NUM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH_NUM-1:0] input_signal,
    output logic [CH_NUM-1:0] level_out,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_ch,
    output logic              evt_pol,
    output logic [CH_NUM-1:0] overflow,
    input  logic              ovf_clr
);

    logic [CH_NUM-1:0]   w_pos;
    logic [CH_NUM-1:0]   w_neg;
    logic [CH_NUM-1:0]   w_evt;
    logic [CH_NUM-1:0]   w_grant;
    logic [CH_NUM-1:0]   w_ovf_set;
    logic [CH_NUM-1:0]   r_pend;
    logic [CH_NUM-1:0]   r_pol;
    logic [CH_NUM-1:0]   r_ovf;
    logic [c_MAX_CH-1:0] w_req;
    logic [CH_W-1:0]     w_sel;
    logic [CH_W-1:0]     r_ptr;
    logic [CH_W-1:0]     r_evt_ch;
    logic                r_evt_pol;
    logic                w_take;
    arb_state_t          r_state;
    arb_state_t          w_state_nxt;

    // ------------------------------------------------------------------
    // Per-channel conditioning
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
            input_conditioner #(
                .SYNC_STAGES (SYNC_STAGES),
                .DEB_LEN     (DEB_LEN),
                .INIT_VAL    (INIT_VAL)
            ) u_cond (
                .clk   (clk),
                .rst_n (rst_n),
                .raw   (input_signal[g]),
                .level (level_out[g]),
                .pos   (w_pos[g]),
                .neg   (w_neg[g])
            );

            assign w_evt[g] = (POS_ENABLE && w_pos[g]) || (NEG_ENABLE && w_neg[g]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arbiter next-state. Selection looks only at registered pend bits,
    // so edges arriving on this clock wait for the next one.
    // ------------------------------------------------------------------
    always_comb begin
        w_req              = '0;
        w_req[CH_NUM-1:0]  = r_pend;
        w_sel              = CH_W'(rr_next(w_req, 4'(r_ptr), CH_NUM));
        w_state_nxt        = r_state;
        w_take             = 1'b0;
        case (r_state)
            IDLE: begin
                if (|r_pend) begin
                    w_take      = 1'b1;
                    w_state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (evt_ready) begin
                    if (|r_pend) begin
                        w_take = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_grant = '0;
        if (w_take) begin
            w_grant[w_sel] = 1'b1;
        end
        // A slot being captured on the same edge as a new event hands its old
        // event to the arbiter, so nothing is lost and no overflow is flagged.
        w_ovf_set = w_evt & r_pend & ~w_grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= CH_W'(CH_NUM - 1);
            r_evt_ch  <= '0;
            r_evt_pol <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_ptr     <= w_sel;
                r_evt_ch  <= w_sel;
                r_evt_pol <= r_pol[w_sel];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending slots and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_pol  <= '0;
            r_ovf  <= '0;
        end else begin
            r_pend <= w_evt | (r_pend & ~w_grant);
            r_pol  <= (w_evt & w_pos) | (r_pol & ~w_evt);
            r_ovf  <= w_ovf_set | (r_ovf & ~{CH_NUM{ovf_clr}});
        end
    end

    assign evt_valid = (r_state == PRESENT);
    assign evt_ch    = r_evt_ch;
    assign evt_pol   = r_evt_pol;
    assign overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_input_event_arbiter.sv
// ============================================================================
// Module      : tb_input_event_arbiter
// Description : Self-checking bench for input_event_arbiter. A behavioural
//               model tracks sampled history, debounce run lengths, pending
//               events and round-robin order; directed scenarios add
//               constant-expectation checks.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_input_event_arbiter;

    localparam int c_CH     = 4;
    localparam int c_SYNC   = 2;
    localparam int c_DEB    = 5;
    localparam bit c_POS_EN = 1'b1;
    localparam bit c_NEG_EN = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] input_signal;
    logic [3:0] level_out;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_ch;
    logic       evt_pol;
    logic [3:0] overflow;
    logic       ovf_clr;

    // Second instance with falling-edge events disabled
    logic [3:0] in_b;
    logic [3:0] level_b;
    logic       valid_b;
    logic       ready_b = 1'b1;
    logic [1:0] ch_b;
    logic       pol_b;
    logic [3:0] ovf_b;
    logic       ovf_clr_b = 1'b0;

    always #5 clk = ~clk;

    input_event_arbiter #(
        .CH_NUM(c_CH), .SYNC_STAGES(c_SYNC), .DEB_LEN(c_DEB),
        .INIT_VAL(1'b0), .POS_ENABLE(1'b1), .NEG_ENABLE(1'b1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .input_signal(input_signal), .level_out(level_out),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch), .evt_pol(evt_pol),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    input_event_arbiter #(
        .CH_NUM(c_CH), .SYNC_STAGES(c_SYNC), .DEB_LEN(c_DEB),
        .INIT_VAL(1'b0), .POS_ENABLE(1'b1), .NEG_ENABLE(1'b0)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .input_signal(in_b), .level_out(level_b),
        .evt_valid(valid_b), .evt_ready(ready_b), .evt_ch(ch_b), .evt_pol(pol_b),
        .overflow(ovf_b), .ovf_clr(ovf_clr_b)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    bit m_hist [c_CH][c_SYNC];   // [0] = most recent raw sample
    bit m_lvl  [c_CH];
    int m_run  [c_CH];           // consecutive samples disagreeing with level
    bit m_pend [c_CH];
    bit m_pol  [c_CH];
    bit m_ovf  [c_CH];
    bit m_valid;
    bit m_evpol;
    int m_ch;
    int m_ptr;

    function automatic logic [31:0] pack(input bit v[c_CH]);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < c_CH; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < c_CH; i++) begin
            for (int s = 0; s < c_SYNC; s++) m_hist[i][s] = 1'b0;
            m_lvl[i] = 1'b0; m_run[i] = 0; m_pend[i] = 1'b0; m_pol[i] = 1'b0; m_ovf[i] = 1'b0;
        end
        m_valid = 1'b0; m_evpol = 1'b0; m_ch = 0; m_ptr = c_CH - 1;
    endtask

    task automatic model_step();
        bit flip [c_CH];
        bit so;
        bit hs;
        int pick;
        for (int i = 0; i < c_CH; i++) begin
            so      = m_hist[i][c_SYNC-1];
            flip[i] = 1'b0;
            if (so != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == c_DEB) begin
                    m_lvl[i] = so; m_run[i] = 0; flip[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
            for (int s = c_SYNC - 1; s > 0; s--) m_hist[i][s] = m_hist[i][s-1];
            m_hist[i][0] = input_signal[i];
        end
        if (ovf_clr) for (int i = 0; i < c_CH; i++) m_ovf[i] = 1'b0;
        hs = m_valid && evt_ready;
        if (!m_valid || hs) begin
            pick = -1;
            for (int k = 1; k <= c_CH; k++)
                if (pick < 0 && m_pend[(m_ptr + k) % c_CH]) pick = (m_ptr + k) % c_CH;
            if (pick >= 0) begin
                m_valid = 1'b1; m_ch = pick; m_evpol = m_pol[pick]; m_ptr = pick; m_pend[pick] = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < c_CH; i++) begin
            if (flip[i] && (m_lvl[i] ? c_POS_EN : c_NEG_EN)) begin
                if (m_pend[i]) m_ovf[i] = 1'b1;
                m_pend[i] = 1'b1;
                m_pol[i]  = m_lvl[i];
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check_value("level_out", 32'(level_out), pack(m_lvl));
            check_value("evt_valid", 32'(evt_valid), 32'(m_valid));
            check_value("evt_ch",    32'(evt_ch),    32'(m_ch));
            check_value("evt_pol",   32'(evt_pol),   32'(m_evpol));
            check_value("overflow",  32'(overflow),  pack(m_ovf));
        end
    end

    // ------------------------------------------------------------------
    // Handshake logs (values seen just before the accepting edge)
    // ------------------------------------------------------------------
    int cyc = 0;
    int hs_ch[$];
    int hs_pol[$];
    int hs_cyc[$];
    int hb_ch[$];
    int hb_pol[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && evt_valid && evt_ready) begin
            hs_ch.push_back(int'(evt_ch)); hs_pol.push_back(int'(evt_pol)); hs_cyc.push_back(cyc);
        end
        if (rst_n && valid_b && ready_b) begin
            hb_ch.push_back(int'(ch_b)); hb_pol.push_back(int'(pol_b));
        end
    end

    function automatic int q_get(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_log();
        hs_ch.delete(); hs_pol.delete(); hs_cyc.delete();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lvl_edge, v_edge, v_cnt, v_ch, v_pol;
        rst_n = 1'b0; input_signal = '0; in_b = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_value("rst_level",   32'(level_out), 32'h0);
        check_value("rst_valid",   32'(evt_valid), 32'h0);
        check_value("rst_ch",      32'(evt_ch),    32'h0);
        check_value("rst_pol",     32'(evt_pol),   32'h0);
        check_value("rst_ovf",     32'(overflow),  32'h0);
        rst_n = 1'b1; chk_en = 1'b1;

        // Latency of a single rising edge on ch0
        evt_ready = 1'b1; input_signal[0] = 1'b1;
        lvl_edge = 0; v_edge = 0; v_cnt = 0; v_ch = -1; v_pol = -1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            if (level_out[0] && lvl_edge == 0) lvl_edge = e;
            if (evt_valid) begin
                v_cnt++;
                if (v_edge == 0) v_edge = e;
                v_ch = int'(evt_ch); v_pol = int'(evt_pol);
            end
        end
        check_value("lat_level_edge", 32'(lvl_edge), 32'd7);
        check_value("lat_valid_edge", 32'(v_edge),   32'd8);
        check_value("lat_valid_cnt",  32'(v_cnt),    32'd1);
        check_value("lat_ch",         32'(v_ch),     32'd0);
        check_value("lat_pol",        32'(v_pol),    32'd1);
        @(negedge clk);

        // Short glitch on ch1 is rejected
        clear_log();
        input_signal[1] = 1'b1;
        repeat (3) @(negedge clk);
        input_signal[1] = 1'b0;
        repeat (15) @(negedge clk);
        check_value("glitch_level", 32'(level_out[1]), 32'h0);
        check_value("glitch_evts",  32'(hs_ch.size()), 32'd0);
        check_value("glitch_ovf",   32'(overflow),     32'h0);

        // Simultaneous rises on ch0/2/3 after reset, then rr order
        input_signal = '0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; clear_log();
        input_signal = 4'b1101;
        repeat (15) @(negedge clk);
        check_value("rr_count", 32'(hs_ch.size()), 32'd3);
        check_value("rr_ch0",   32'(q_get(hs_ch, 0)), 32'd0);
        check_value("rr_ch1",   32'(q_get(hs_ch, 1)), 32'd2);
        check_value("rr_ch2",   32'(q_get(hs_ch, 2)), 32'd3);
        check_value("rr_b2b",   32'(q_get(hs_cyc, 2) - q_get(hs_cyc, 0)), 32'd2);
        clear_log();
        input_signal = 4'b1000;
        repeat (15) @(negedge clk);
        check_value("rr_wrap_count", 32'(hs_ch.size()), 32'd2);
        check_value("rr_wrap_first", 32'(q_get(hs_ch, 0)), 32'd0);
        check_value("rr_wrap_next",  32'(q_get(hs_ch, 1)), 32'd2);
        check_value("rr_wrap_pol",   32'(q_get(hs_pol, 0)), 32'd0);

        // Back-pressure: ch1 toggles 1->0->1 while ready is low
        evt_ready = 1'b0;
        input_signal[1] = 1'b1; repeat (10) @(negedge clk);
        input_signal[1] = 1'b0; repeat (10) @(negedge clk);
        input_signal[1] = 1'b1; repeat (15) @(negedge clk);
        check_value("bp_valid", 32'(evt_valid), 32'h1);
        check_value("bp_ch",    32'(evt_ch),    32'd1);
        check_value("bp_pol",   32'(evt_pol),   32'd1);
        check_value("bp_ovf",   32'(overflow),  32'h2);
        clear_log();
        evt_ready = 1'b1;
        repeat (4) @(negedge clk);
        check_value("bp_drain_cnt", 32'(hs_ch.size()), 32'd2);
        check_value("bp_drain_ch",  32'(q_get(hs_ch, 1)), 32'd1);
        check_value("bp_drain_pol", 32'(q_get(hs_pol, 1)), 32'd1);
        ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
        check_value("ovf_cleared", 32'(overflow), 32'h0);

        // Falling edges suppressed on the second instance
        in_b[2] = 1'b1; repeat (15) @(negedge clk);
        in_b[2] = 1'b0; repeat (15) @(negedge clk);
        check_value("noneg_cnt",   32'(hb_ch.size()),     32'd1);
        check_value("noneg_ch",    32'(q_get(hb_ch, 0)),  32'd2);
        check_value("noneg_pol",   32'(q_get(hb_pol, 0)), 32'd1);
        check_value("noneg_level", 32'(level_b),          32'h0);

        // Randomised traffic with bursts of back-pressure
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < c_CH; i++)
                if ($urandom_range(0, 7) == 0) input_signal[i] = ~input_signal[i];
            if ((c % 200) < 100) evt_ready = ($urandom_range(0, 3) != 0);
            else                 evt_ready = ($urandom_range(0, 7) == 0);
            ovf_clr = ($urandom_range(0, 31) == 0);
            @(negedge clk);
        end

        // Reset while an event is presented and others are pending
        ovf_clr = 1'b0; evt_ready = 1'b0;
        input_signal = ~input_signal;
        repeat (12) @(negedge clk);
        check_value("prerst_valid", 32'(evt_valid), 32'h1);
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        check_value("async_valid", 32'(evt_valid), 32'h0);
        input_signal = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; clear_log(); evt_ready = 1'b1;
        repeat (20) @(negedge clk);
        check_value("postrst_evts",  32'(hs_ch.size()), 32'd0);
        check_value("postrst_level", 32'(level_out),    32'h0);
        check_value("postrst_valid", 32'(evt_valid),    32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/input_event_arbiter.md
Name: input_event_arbiter

Overview:
Conditions CH_NUM asynchronous inputs (buttons, status lines) and funnels their edges into one event stream. Per channel it synchronises, debounces and edge-detects the input, then queues one pending event per channel. A round-robin scheduler shares a single valid/ready event port between all channels. It sits between raw pins and the control FSMs in the user `test` logic.

Parameters:
CH_NUM, 4, number of input channels (1..16)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEB_LEN, 5, consecutive differing samples required to accept a new level (>=1)
INIT_VAL, 1'b0, reset value of synchroniser flops and debounced levels
POS_ENABLE, 1, generate events on rising debounced edges
NEG_ENABLE, 1, generate events on falling debounced edges

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
input_signal  input  CH_NUM  raw asynchronous inputs
level_out  output  CH_NUM  debounced levels
evt_valid  output  1  event available
evt_ready  input  1  consumer accepts event
evt_ch  output  CH_W  channel index of event; CH_W = max(1, clog2(CH_NUM))
evt_pol  output  1  1 = rising edge, 0 = falling edge
overflow  output  CH_NUM  sticky: an event was overwritten before it was granted
ovf_clr  input  1  clears overflow

Behaviour:
- Reset is asynchronous. Sync flops and level_out = INIT_VAL. Counters = 0, pending = 0, overflow = 0. evt_valid = 0, evt_ch = 0, evt_pol = 0, rr pointer = CH_NUM-1. Asserting reset mid-operation discards all pending and presented events.
- Sync: SYNC_STAGES flop chain. Edge 1 is the first edge that samples a new raw value. sync_out changes at edge SYNC_STAGES.
- Debounce: count increments each cycle sync_out != level and clears when they are equal. On the edge where the count would reach DEB_LEN, level flips and count returns to 0. Net effect: level flips at edge SYNC_STAGES+DEB_LEN. A glitch shorter than DEB_LEN samples never changes level.
- Edge: on the same edge level flips, pend[ch] is set and pol[ch] = new level, subject to POS_ENABLE/NEG_ENABLE.
- Pending already set, new edge arrives, and the slot is not being captured that cycle: pol is overwritten with the newest polarity and overflow[ch] is set.
- Slot captured by the arbiter on the same edge as a new edge: the old event is granted, pend stays set with the new polarity, and overflow is not set.
- Arbiter FSM:
  - IDLE: evt_valid = 0. If any pend bit is set, select the first set bit searching from ptr+1 upward with wrap. Load evt_ch/evt_pol, clear that pend bit, ptr = ch, go to PRESENT.
  - PRESENT: evt_valid = 1. evt_ch/evt_pol are held stable until evt_valid && evt_ready.
  - On handshake: if any pend bit is set (excluding bits set on this same edge), select the next one back-to-back and stay in PRESENT; otherwise go to IDLE.
- Raw-to-valid latency = SYNC_STAGES + DEB_LEN + 1 edges. With defaults, evt_valid is high after edge 8.
- evt_ready while evt_valid = 0 is ignored.
- ovf_clr clears overflow. If a set and a clear occur on the same edge, the set wins.
- Sustained throughput: one event per cycle while evt_ready is held high.

Decomposition:
- Package input_event_pkg holds:
  - arbiter state enum {IDLE, PRESENT}
  - CH_W width function (max(1, clog2))
  - round-robin next-index function
- Sub-module input_conditioner (one instance per channel via generate) performs sync, debounce and edge pulses. It has params SYNC_STAGES, DEB_LEN, INIT_VAL and outputs level, pos, neg.
- Pending slots, overflow and the arbiter live in the top module.

Test Plan:
- Reset, then input_signal[0] 0->1 held, evt_ready = 1 -> level_out[0] rises at edge 7. evt_valid is high for one cycle after edge 8 with evt_ch = 0, evt_pol = 1.
- 3-cycle pulse on ch1 with DEB_LEN = 5 -> level_out and evt_valid stay 0 and overflow = 0.
- ch0, ch2, ch3 rise on the same cycle, evt_ready = 1 -> events granted back-to-back in order 0, 2, 3 on consecutive cycles. A new ch0 event afterwards is granted after ch3, respecting rr order.
- evt_ready = 0 while ch1 toggles 1->0->1 (each held 10 cycles) -> evt_ch/evt_pol stay frozen at the first event. overflow[1] = 1 and pol[1] holds the newest edge (rising). ovf_clr clears overflow.
- NEG_ENABLE = 0, ch2 toggles 0->1->0 -> exactly one event (pol = 1) is produced.
- rst_n pulsed low while evt_valid = 1 with other events pending -> evt_valid drops immediately (asynchronously). After release there are no events and level_out = INIT_VAL.
